// File: rtl/jt12_wr_arb.sv
// Two-port write arbiter in front of the jt12 register bus. It keeps a private address
// latch for each requester and holds every data write until the chip's busy flag clears.
module jt12_wr_arb #(
  parameter int BUSY_RISE_WIN = 4,
  parameter int BUSY_TMO      = 64
) (
  input  logic       rst,
  input  logic       clk,
  input  logic       cen,
  input  logic       req0,
  input  logic [1:0] addr0,
  input  logic [7:0] din0,
  output logic       ack0,
  input  logic       req1,
  input  logic [1:0] addr1,
  input  logic [7:0] din1,
  output logic       ack1,
  output logic [1:0] ym_addr,
  output logic [7:0] ym_din,
  output logic       ym_cs_n,
  output logic       ym_wr_n,
  input  logic       ym_busy,
  output logic       owner,
  output logic       tmo_err
);

  localparam int CNT_LIM = (BUSY_TMO > BUSY_RISE_WIN) ? BUSY_TMO : BUSY_RISE_WIN;
  localparam int CNT_W   = $clog2(CNT_LIM + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_SHADOW, S_ADDR_WR, S_DATA_WR, S_BUSY_RISE, S_BUSY_FALL, S_DONE
  } state_t;

  typedef struct packed {
    logic       part;
    logic [7:0] regn;
  } shadow_t;

  state_t             state_q, state_d;
  shadow_t [1:0]      shadow_q, shadow_d;
  logic               owner_q, owner_d;
  logic               last_q, last_d;
  logic               op_part_q, op_part_d;
  logic [7:0]         op_din_q, op_din_d;
  logic               chip_valid_q, chip_valid_d;
  logic               chip_part_q, chip_part_d;
  logic [7:0]         chip_reg_q, chip_reg_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [1:0]         ym_addr_q;
  logic [7:0]         ym_din_q;
  logic               ack0_q, ack0_d, ack1_q, ack1_d;
  logic               tmo_err_q, tmo_err_d;

  logic               gnt;
  logic [1:0]         addr_sel;
  logic [7:0]         din_sel;
  logic [CNT_W-1:0]   cnt_inc;
  logic               strobe;

  // Strobes are gated combinationally by cen so they can never appear outside a cen
  // cycle; the async reset of state_q therefore releases them immediately.
  assign strobe  = cen && (state_q == S_ADDR_WR || state_q == S_DATA_WR);
  assign ym_cs_n = ~strobe;
  assign ym_wr_n = ~strobe;

  always_comb begin
    ym_addr = ym_addr_q;
    ym_din  = ym_din_q;
    if (cen && state_q == S_ADDR_WR) begin
      ym_addr = {op_part_q, 1'b0};
      ym_din  = shadow_q[owner_q].regn;
    end else if (cen && state_q == S_DATA_WR) begin
      ym_addr = {op_part_q, 1'b1};
      ym_din  = op_din_q;
    end
  end

  assign gnt      = (req0 && req1) ? ~last_q : req1;
  assign addr_sel = gnt ? addr1 : addr0;
  assign din_sel  = gnt ? din1 : din0;
  assign cnt_inc  = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + 1'b1;

  // NOTE: every next-state variable gets its hold value first, so no path through the
  // case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_d      = state_q;
    shadow_d     = shadow_q;
    owner_d      = owner_q;
    last_d       = last_q;
    op_part_d    = op_part_q;
    op_din_d     = op_din_q;
    chip_valid_d = chip_valid_q;
    chip_part_d  = chip_part_q;
    chip_reg_d   = chip_reg_q;
    cnt_d        = cnt_q;
    tmo_err_d    = tmo_err_q;
    ack0_d       = 1'b0;
    ack1_d       = 1'b0;

    case (state_q)
      S_IDLE: if (req0 || req1) begin
        owner_d   = gnt;
        op_part_d = addr_sel[1];
        op_din_d  = din_sel;
        if (!addr_sel[0]) begin
          state_d = S_SHADOW;
        end else begin
          shadow_d[gnt].part = addr_sel[1];
          if (!chip_valid_q || chip_part_q != addr_sel[1] ||
              chip_reg_q != shadow_q[gnt].regn)
            state_d = S_ADDR_WR;
          else
            state_d = S_DATA_WR;
        end
      end
      S_SHADOW: begin
        shadow_d[owner_q] = '{part: op_part_q, regn: op_din_q};
        state_d           = S_DONE;
      end
      S_ADDR_WR: if (cen) begin
        chip_valid_d = 1'b1;
        chip_part_d  = op_part_q;
        chip_reg_d   = shadow_q[owner_q].regn;
        state_d      = S_DATA_WR;
      end
      S_DATA_WR: if (cen) begin
        cnt_d   = '0;
        state_d = S_BUSY_RISE;
      end
      S_BUSY_RISE: if (cen) begin
        if (ym_busy) begin
          cnt_d   = '0;
          state_d = S_BUSY_FALL;
        end else if (cnt_inc >= CNT_W'(BUSY_RISE_WIN)) begin
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      S_BUSY_FALL: if (cen) begin
        if (!ym_busy) begin
          state_d = S_DONE;
        end else if (cnt_inc >= CNT_W'(BUSY_TMO)) begin
          tmo_err_d = 1'b1;
          state_d   = S_DONE;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      S_DONE: begin
        last_d  = owner_q;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // The completion pulse is registered so it lines up with the single DONE cycle.
    if (state_d == S_DONE) begin
      ack0_d = ~owner_q;
      ack1_d = owner_q;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only; the shadows are tiny and
  // carry architectural reset values, so they are reset like any other flop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      shadow_q     <= '0;
      owner_q      <= 1'b0;
      last_q       <= 1'b1;
      op_part_q    <= 1'b0;
      op_din_q     <= 8'h00;
      chip_valid_q <= 1'b0;
      chip_part_q  <= 1'b0;
      chip_reg_q   <= 8'h00;
      cnt_q        <= '0;
      ym_addr_q    <= 2'b00;
      ym_din_q     <= 8'h00;
      ack0_q       <= 1'b0;
      ack1_q       <= 1'b0;
      tmo_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      shadow_q     <= shadow_d;
      owner_q      <= owner_d;
      last_q       <= last_d;
      op_part_q    <= op_part_d;
      op_din_q     <= op_din_d;
      chip_valid_q <= chip_valid_d;
      chip_part_q  <= chip_part_d;
      chip_reg_q   <= chip_reg_d;
      cnt_q        <= cnt_d;
      ym_addr_q    <= ym_addr;
      ym_din_q     <= ym_din;
      ack0_q       <= ack0_d;
      ack1_q       <= ack1_d;
      tmo_err_q    <= tmo_err_d;
    end
  end

  assign ack0    = ack0_q;
  assign ack1    = ack1_q;
  assign owner   = owner_q;
  assign tmo_err = tmo_err_q;

endmodule
